// File: rtl/fp8_pkg.sv
// Shared FP8 definitions: flag positions, result record and special-value encodings.
package fp8_pkg;

  localparam int FLAG_NAN = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;

  localparam int WORD_W = 8;

  typedef enum logic [1:0] {
    K_FIN  = 2'd0,
    K_ZERO = 2'd1,
    K_INF  = 2'd2,
    K_NAN  = 2'd3
  } kind_e;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [3:0]        flags;
  } lane_res_t;

  function automatic int bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Width of the decode->round hand-off: kind, sign, widened exponent, mantissa product.
  function automatic int mid_width(input int exp_w, input int man_w);
    return 2 + 1 + (exp_w + 3) + 2 * (man_w + 1);
  endfunction

  function automatic logic [WORD_W-1:0] inf_word(input int exp_w, input int man_w,
                                                 input logic sign);
    logic [WORD_W-1:0] w;
    w = WORD_W'(((1 << exp_w) - 1) << man_w);
    w[WORD_W-1] = sign;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] max_finite_word(input int exp_w, input int man_w,
                                                        input logic sign);
    logic [WORD_W-1:0] w;
    w = WORD_W'((((1 << exp_w) - 2) << man_w) | ((1 << man_w) - 1));
    w[WORD_W-1] = sign;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] nan_word(input int exp_w, input int man_w);
    return WORD_W'((1 << (exp_w + man_w)) - 1);
  endfunction

endpackage

// File: rtl/fp8_mul_lane.sv
// One FP8 multiplier lane as two combinational halves (decode/multiply, normalise/round/pack);
// the parent decides where the registers between and after them go.
module fp8_mul_lane
  import fp8_pkg::*;
#(
  parameter int EXP_W    = 4,
  parameter int MAN_W    = 3,
  parameter bit SATURATE = 1'b0
) (
  input  logic [EXP_W+MAN_W:0]              a_i,
  input  logic [EXP_W+MAN_W:0]              b_i,
  output logic [mid_width(EXP_W, MAN_W)-1:0] mid_o,
  input  logic [mid_width(EXP_W, MAN_W)-1:0] mid_i,
  output lane_res_t                          res_o
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int EW = EXP_W + 3;
  localparam int PW = 2 * (MAN_W + 1);
  localparam int FW = MAN_W + 1;
  localparam logic signed [EW-1:0] E_MAX    = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] E_BIAS   = EW'(bias(EXP_W));
  localparam logic [PW-1:0]        LOW_MASK = PW'((1 << (MAN_W - 1)) - 1);

  typedef struct packed {
    kind_e                 kind;
    logic                  sign;
    logic signed [EW-1:0]  exp;
    logic [PW-1:0]         prod;
  } mid_t;

  mid_t mid_c, mid_r;

  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign ea = a_i[W-2:MAN_W];
  assign eb = b_i[W-2:MAN_W];
  assign ma = a_i[MAN_W-1:0];
  assign mb = b_i[MAN_W-1:0];

  // Subnormals count as zero: exp field 0 flushes regardless of mantissa.
  assign a_zero = ~|ea;
  assign b_zero = ~|eb;
  assign a_inf  = (&ea) & ~|ma;
  assign b_inf  = (&eb) & ~|mb;
  assign a_nan  = (&ea) & |ma;
  assign b_nan  = (&eb) & |mb;

  always_comb begin
    mid_c.sign = a_i[W-1] ^ b_i[W-1];
    mid_c.exp  = EW'(ea) + EW'(eb) - E_BIAS;
    mid_c.prod = PW'({1'b1, ma}) * PW'({1'b1, mb});
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) mid_c.kind = K_NAN;
    else if (a_inf || b_inf)                                       mid_c.kind = K_INF;
    else if (a_zero || b_zero)                                     mid_c.kind = K_ZERO;
    else                                                           mid_c.kind = K_FIN;
  end

  assign mid_o = mid_c;
  assign mid_r = mid_i;

  logic                 hi, guard, sticky, round_up;
  logic [PW-1:0]        pn;
  logic [MAN_W-1:0]     frac;
  logic [FW-1:0]        frac_r;
  logic signed [EW-1:0] e_n, e_r;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    res_o    = '0;
    hi       = mid_r.prod[PW-1];
    pn       = hi ? (mid_r.prod >> 1) : mid_r.prod;
    e_n      = mid_r.exp + EW'(hi);
    frac     = pn[PW-3 -: MAN_W];
    guard    = pn[MAN_W-1];
    sticky   = (|(pn & LOW_MASK)) | (hi & mid_r.prod[0]);
    round_up = guard & (sticky | frac[0]);
    frac_r   = {1'b0, frac} + FW'(round_up);
    e_r      = e_n + EW'(frac_r[MAN_W]);

    unique case (mid_r.kind)
      K_NAN: begin
        res_o.word            = nan_word(EXP_W, MAN_W);
        res_o.flags[FLAG_NAN] = 1'b1;
      end
      K_INF:  res_o.word = inf_word(EXP_W, MAN_W, mid_r.sign);
      K_ZERO: res_o.word[W-1] = mid_r.sign;
      K_FIN: begin
        if (e_r >= E_MAX) begin
          res_o.word            = SATURATE ? max_finite_word(EXP_W, MAN_W, mid_r.sign)
                                           : inf_word(EXP_W, MAN_W, mid_r.sign);
          res_o.flags[FLAG_OVF] = 1'b1;
          res_o.flags[FLAG_INX] = 1'b1;
        end else if (e_r <= 0) begin
          res_o.word[W-1]       = mid_r.sign;
          res_o.flags[FLAG_UNF] = 1'b1;
          res_o.flags[FLAG_INX] = 1'b1;
        end else begin
          res_o.word            = {mid_r.sign, e_r[EXP_W-1:0], frac_r[MAN_W-1:0]};
          res_o.flags[FLAG_INX] = guard | sticky;
        end
      end
    endcase
  end

endmodule

// File: rtl/fp8_mul_pipe.sv
// Streaming multi-lane FP8 multiplier: PIPE_STAGES valid-tagged slots sharing one advance enable.
module fp8_mul_pipe
  import fp8_pkg::*;
#(
  parameter int EXP_W       = 4,
  parameter int MAN_W       = 3,
  parameter int LANES       = 2,
  parameter int PIPE_STAGES = 2,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]  a,
  input  logic [LANES*(1+EXP_W+MAN_W)-1:0]  b,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [LANES*(1+EXP_W+MAN_W)-1:0]  out_data,
  output logic [LANES*4-1:0]                out_flags
);

  localparam int W         = 1 + EXP_W + MAN_W;
  localparam int MID_W     = mid_width(EXP_W, MAN_W);
  localparam int RES_W     = $bits(lane_res_t);
  // Slot 0 holds the decode/multiply half when there is room for it; the rest carry results.
  localparam int RES_SLOTS = (PIPE_STAGES > 1) ? PIPE_STAGES - 1 : 1;
  localparam int FIRST     = PIPE_STAGES - RES_SLOTS;

  logic                   adv, accept;
  logic [PIPE_STAGES-1:0] vld_q, vld_d;
  logic [LANES*MID_W-1:0] mid_c, mid_src;
  logic [LANES*RES_W-1:0] res_c;
  logic [LANES*RES_W-1:0] res_q [RES_SLOTS];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv;

  always_comb begin
    vld_d    = '0;
    vld_d[0] = accept;
    for (int s = 1; s < PIPE_STAGES; s++) vld_d[s] = vld_q[s-1];
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst)      vld_q <= '0;
    else if (adv) vld_q <= vld_d;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    fp8_mul_lane #(.EXP_W(EXP_W), .MAN_W(MAN_W), .SATURATE(SATURATE)) u_lane (
      .a_i   (a[i*W +: W]),
      .b_i   (b[i*W +: W]),
      .mid_o (mid_c[i*MID_W +: MID_W]),
      .mid_i (mid_src[i*MID_W +: MID_W]),
      .res_o (res_c[i*RES_W +: RES_W])
    );
  end

  if (PIPE_STAGES > 1) begin : g_mid
    logic [LANES*MID_W-1:0] mid_q;
    always_ff @(posedge clk) begin
      if (rst)                   mid_q <= '0;
      else if (adv && vld_d[0])  mid_q <= mid_c;
    end
    assign mid_src = mid_q;
  end else begin : g_nomid
    assign mid_src = mid_c;
  end

  // Data moves only with its valid tag, so bubbles never overwrite the last result shown.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: stage data is reset too because out_data/out_flags must read 0 straight after reset.
      for (int r = 0; r < RES_SLOTS; r++) res_q[r] <= '0;
    end else if (adv) begin
      if (vld_d[FIRST]) res_q[0] <= res_c;
      for (int r = 1; r < RES_SLOTS; r++)
        if (vld_d[FIRST+r]) res_q[r] <= res_q[r-1];
    end
  end

  assign out_valid = vld_q[PIPE_STAGES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_out
    lane_res_t r;
    assign r                   = res_q[RES_SLOTS-1][i*RES_W +: RES_W];
    assign out_data[i*W +: W]  = r.word;
    assign out_flags[i*4 +: 4] = r.flags;
  end

endmodule

// File: tb/tb_fp8_mul_pipe.sv
// Self-checking bench for fp8_mul_pipe: real-valued reference model, scoreboard, directed vectors.
module tb_fp8_mul_pipe;

  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int LANES = 2;
  localparam int PIPE  = 2;
  localparam bit SAT   = 1'b0;
  localparam int W     = 1 + EXP_W + MAN_W;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 out_ready = 1'b1;
  logic [LANES*W-1:0]   a = '0;
  logic [LANES*W-1:0]   b = '0;
  logic                 in_ready, out_valid;
  logic [LANES*W-1:0]   out_data;
  logic [LANES*4-1:0]   out_flags;

  always #5 clk = ~clk;

  fp8_mul_pipe #(
    .EXP_W(EXP_W), .MAN_W(MAN_W), .LANES(LANES), .PIPE_STAGES(PIPE), .SATURATE(SAT)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: exact real arithmetic, then round-to-nearest-even into the format.
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int k = 0; k < n; k++) r = r * 2.0;
    else        for (int k = 0; k < -n; k++) r = r / 2.0;
    return r;
  endfunction

  function automatic logic [11:0] model_lane(input logic [7:0] x, input logic [7:0] y);
    int  emax = (1 << EXP_W) - 1;
    int  bs   = (1 << (EXP_W - 1)) - 1;
    int  ex = int'(x[W-2:MAN_W]), ey = int'(y[W-2:MAN_W]);
    int  mx = int'(x[MAN_W-1:0]), my = int'(y[MAN_W-1:0]);
    bit  xn = (ex == emax) && (mx != 0), yn = (ey == emax) && (my != 0);
    bit  xi = (ex == emax) && (mx == 0), yi = (ey == emax) && (my == 0);
    bit  xz = (ex == 0), yz = (ey == 0);
    logic s = x[W-1] ^ y[W-1];
    real v, q, fr;
    int  e, r, be;
    bit  inx;
    if (xn || yn || (xi && yz) || (yi && xz)) return {8'((1 << (EXP_W + MAN_W)) - 1), 4'b1000};
    if (xi || yi) return {s, 7'(emax << MAN_W), 4'b0000};
    if (xz || yz) return {s, 7'd0, 4'b0000};
    v = (1.0 + real'(mx) / pow2(MAN_W)) * pow2(ex - bs)
      * (1.0 + real'(my) / pow2(MAN_W)) * pow2(ey - bs);
    e = 0;
    while (v >= 2.0) begin v = v / 2.0; e++; end
    while (v < 1.0)  begin v = v * 2.0; e--; end
    q   = v * pow2(MAN_W);
    r   = $rtoi(q);
    fr  = q - real'(r);
    inx = (fr != 0.0);
    if (fr > 0.5 || (fr == 0.5 && (r % 2) == 1)) r++;
    if (r == (1 << (MAN_W + 1))) begin r = 1 << MAN_W; e++; end
    be = e + bs;
    if (be >= emax)
      return SAT ? {s, 7'((((emax - 1) << MAN_W) | ((1 << MAN_W) - 1))), 4'b0101}
                 : {s, 7'(emax << MAN_W), 4'b0101};
    if (be <= 0) return {s, 7'd0, 4'b0011};
    return {s, 7'((be << MAN_W) | (r - (1 << MAN_W))), {3'b000, inx}};
  endfunction

  typedef struct packed {
    logic [LANES*W-1:0] data;
    logic [LANES*4-1:0] flags;
  } exp_t;

  function automatic exp_t model_vec(input logic [LANES*W-1:0] av, input logic [LANES*W-1:0] bv);
    exp_t        e;
    logic [11:0] lr;
    for (int i = 0; i < LANES; i++) begin
      lr                  = model_lane(av[i*W +: W], bv[i*W +: W]);
      e.data[i*W +: W]    = lr[11:4];
      e.flags[i*4 +: 4]   = lr[3:0];
    end
    return e;
  endfunction

  exp_t q[$];

  // Directed operands with hand-worked results; lane pairs are (2k, 2k+1).
  logic [7:0] va [12] = '{8'h3C, 8'h3C, 8'h39, 8'h39, 8'h77, 8'h78,
                          8'hB8, 8'h08, 8'h01, 8'h88, 8'h39, 8'h30};
  logic [7:0] vb [12] = '{8'h3C, 8'h40, 8'h3C, 8'h39, 8'h40, 8'h00,
                          8'h78, 8'h08, 8'h40, 8'h38, 8'h3E, 8'h08};
  logic [7:0] ew [12] = '{8'h41, 8'h44, 8'h3E, 8'h3A, 8'h78, 8'h7F,
                          8'hF8, 8'h00, 8'h00, 8'h88, 8'h40, 8'h00};
  logic [3:0] ef [12] = '{4'h0, 4'h0, 4'h1, 4'h1, 4'h5, 4'h8,
                          4'h0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h3};

  // Single compare process: handshake rule, stall stability, and in-order scoreboard.
  bit                 prev_stall = 1'b0;
  logic [LANES*W-1:0] prev_data;
  logic [LANES*4-1:0] prev_flags;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_data",  out_data,  prev_data);
        check("stall_flags", out_flags, prev_flags);
      end
      if (out_valid && out_ready) begin
        n_out++;
        check("out_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check("sb_data",  out_data,  e.data);
          check("sb_flags", out_flags, e.flags);
        end
      end
      if (in_valid && in_ready) q.push_back(model_vec(a, b));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_flags = out_flags;
    end
  end

  // Called at posedge+1 with the pipeline empty and out_ready high.
  task automatic run_vec(input int k, input string tag);
    int lat;
    in_valid = 1'b1;
    a = {va[2*k+1], va[2*k]};
    b = {vb[2*k+1], vb[2*k]};
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, lat, PIPE);
    check({tag, "_data"},  out_data,  {ew[2*k+1], ew[2*k]});
    check({tag, "_flags"}, out_flags, {ef[2*k+1], ef[2*k]});
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  idx, cyc, base;
    bit  took;

    for (int k = 0; k < 12; k++)
      check($sformatf("model_pin%0d", k), model_lane(va[k], vb[k]), {ew[k], ef[k]});

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data",  out_data,  '0);
    check("rst_out_flags", out_flags, '0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1'b1);

    for (int k = 0; k < 6; k++) run_vec(k, $sformatf("dir%0d", k));

    // Backpressure: in_valid held, out_ready pattern 1,0,0,1 repeating.
    idx = 0; cyc = 0; base = n_out;
    while (idx < 8 && cyc < 100) begin
      in_valid  = 1'b1;
      a         = {va[11-idx], va[idx]};
      b         = {vb[11-idx], vb[idx]};
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      @(negedge clk);
      took = in_ready;
      @(posedge clk); #1;
      if (took) idx++;
      cyc++;
    end
    check("bp_all_accepted", idx, 8);
    in_valid = 1'b0;
    while (q.size() > 0 && cyc < 200) begin
      out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      @(posedge clk); #1;
      cyc++;
    end
    check("bp_out_count",   n_out - base, 8);
    check("bp_queue_empty", q.size(), 0);

    // Mid-stream reset with two vectors in flight.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = {va[1], va[0]}; b = {vb[1], vb[0]};
    @(posedge clk); #1;
    a = {va[3], va[2]}; b = {vb[3], vb[2]};
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0;
    a = {va[5], va[4]}; b = {vb[5], vb[4]};
    @(posedge clk); #1;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data",  out_data,  '0);
    check("mid_rst_out_flags", out_flags, '0);
    in_valid = 1'b0; rst = 1'b0; out_ready = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    run_vec(3, "post_rst");
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("final_queue_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
